pwm_dac_sink: RTL and testbench
===============================

Name: pwm_dac_sink

Overview:
- Consumer end of the synth sample stream: accepts 14-bit two's-complement samples over a valid/ready handshake and buffers them in a small FIFO.
- Pops one sample per PWM period, converts it to an offset-binary duty value and drives a single-bit PWM audio output.
- Sets the audio sample rate (clk / 2^DUTY_WIDTH) and back-pressures the synth via sample_ready.

Parameters:
- SAMPLE_WIDTH, 14, width of incoming signed sample.
- DUTY_WIDTH, 10, PWM resolution; PWM period = 2^DUTY_WIDTH cycles; must be <= SAMPLE_WIDTH.
- FIFO_DEPTH, 4, sample buffer entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- sample  input  SAMPLE_WIDTH  signed sample from synth
- sample_valid  input  1  sample is valid
- sample_ready  output  1  FIFO can accept a sample
- underrun_clr  input  1  synchronous clear of the underrun flag
- pwm_out  output  1  registered PWM output
- underrun  output  1  sticky: a period started with the FIFO empty
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, fifo_count=0, count=0, duty=2^(DUTY_WIDTH-1) (midscale 512), pwm_out=0, underrun=0. sample_ready=1 once rst deasserts.
- Handshake: sample_ready = (fifo_count != FIFO_DEPTH), combinational from registered state. A push occurs on a rising edge where sample_valid && sample_ready. Data is captured that edge. sample_valid may stay high across cycles, and each accepted cycle is a separate sample.
- Period counter: count increments every cycle, 0 .. 2^DUTY_WIDTH-1, then wraps to 0.
- Pop: on the edge where count == 2^DUTY_WIDTH-1:
  - if the FIFO is non-empty, pop the head and load duty = conv(head);
  - if the FIFO is empty, duty is unchanged and underrun is set to 1.
- Conversion: conv(s) = {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2 : SAMPLE_WIDTH-DUTY_WIDTH]}, i.e. the top DUTY_WIDTH bits of s with the MSB inverted. Examples at defaults: -8192 -> 0, 0 -> 512, 8191 -> 1023, -1 -> 511.
- PWM: pwm_out <= (count < duty) every edge, so pwm_out lags the counter by one cycle. duty=0 gives constant 0. duty=1023 is high for 1023 of 1024 cycles.
- Latency: a sample pushed into an empty FIFO reaches duty at the next wrap edge. It affects pwm_out one cycle after that.
- Simultaneous push and pop: both take effect and fifo_count is unchanged.
  - Push into a full FIFO cannot happen, because ready=0.
  - Push into an empty FIFO on the wrap edge is not bypassed: the pop sees empty, so underrun sets and the pushed sample is used next period.
- Underrun flag: underrun_clr=1 clears it. If the clear coincides with a new underrun event, set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Reset mid-operation: all state returns to reset values immediately. Buffered samples are discarded.

Optional Feature:
- Macro: PWM_DAC_SINK_MUTE_ON_UNDERRUN_EN.
- Defined: on an underrun wrap edge, duty is loaded with midscale 2^(DUTY_WIDTH-1), so output is silent (DC 50%) instead of holding the last value. underrun still sets.
- Not defined: duty holds its previous value on underrun, as in the base behaviour.

Test Plan:
- Reset check: hold rst=0 for 5 cycles, then release with no input. Required:
  - pwm_out=0 during reset;
  - from the first period, pwm_out high exactly 512 of every 1024 cycles;
  - underrun=1 after the first wrap edge (cycle 1024).
- Conversion: push 0x2000 (-8192), 0x0000 and 0x1FFF (8191). Required high-times per period are 0, 512 and 1023 cycles, in order, over consecutive periods.
- Backpressure: hold sample_valid=1 continuously with an incrementing sample. Required:
  - sample_ready falls after 4 accepts (fifo_count=4);
  - exactly one further accept follows each wrap edge;
  - no sample is lost or duplicated across 10 periods.
- Underrun: push 1 sample (0x1000) and wait 3 periods. Required:
  - period 1 high-time is 768, and periods 2–3 also 768 (held);
  - underrun=1 at the second wrap edge;
  - underrun_clr pulse -> 0; it re-sets at the next empty wrap.
  - With the macro defined, periods 2–3 have high-time 512.
- Simultaneous push and pop: FIFO holding 2 entries, push on the wrap edge. Required: fifo_count stays 2 and order is preserved.
- Async reset mid-period: with FIFO=3 entries at count=300, pull rst low between clock edges. Required:
  - pwm_out=0, fifo_count=0 and underrun=0 without waiting for a clock edge;
  - after release, the block behaves as after power-up reset.

Source files
------------

// File: rtl/pwm_dac_sink.sv
// rtl/pwm_dac_sink.sv - PWM DAC sink for the synth sample stream
//
// Purpose:
//   Accepts signed samples over a valid/ready handshake into a small FIFO.
//   Once per PWM period (2^DUTY_WIDTH clocks) it pops one sample, converts it
//   to an offset-binary duty value and drives a single-bit PWM output. The
//   PWM period sets the audio sample rate. A full FIFO back-pressures the
//   synth through sample_ready.
//
// Optional feature (compile-time macro):
//   PWM_DAC_SINK_MUTE_ON_UNDERRUN_EN - when defined, an underrun loads the
//   midscale duty (silence) instead of holding the previous duty.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   sample        in   signed sample from synth [SAMPLE_WIDTH]
//   sample_valid  in   sample is valid
//   sample_ready  out  FIFO can accept a sample
//   underrun_clr  in   synchronous clear of the sticky underrun flag
//   pwm_out       out  registered PWM output
//   underrun      out  sticky: a period started with the FIFO empty
//   fifo_count    out  current FIFO occupancy [log2(FIFO_DEPTH)+1]

module pwm_dac_sink #(
    parameter int SAMPLE_WIDTH = 14,
    parameter int DUTY_WIDTH   = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_WIDTH-1:0]       sample,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          underrun_clr,
    output logic                          pwm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [DUTY_WIDTH-1:0] DUTY_MID = {1'b1, {(DUTY_WIDTH-1){1'b0}}};
    localparam logic [DUTY_WIDTH-1:0] DUTY_TOP = {DUTY_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DUTY_WIDTH-1:0] count_q,    count_d;
    logic [DUTY_WIDTH-1:0] duty_q,     duty_d;
    logic                  pwm_q,      pwm_d;
    logic                  underrun_q, underrun_d;
    logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

    // The FIFO stores already-converted duty values, so only the bits that
    // reach the PWM comparator are kept.
    logic [DUTY_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Conversion: top DUTY_WIDTH bits of the sample with the sign inverted
    // turns two's complement into offset binary (most negative -> 0).
    // ------------------------------------------------------------------
    logic [DUTY_WIDTH-1:0] sample_duty;

    assign sample_duty = {~sample[SAMPLE_WIDTH-1],
                          sample[SAMPLE_WIDTH-2 -: DUTY_WIDTH-1]};

    // Sample LSBs below the PWM resolution are deliberately dropped.
    generate
        if (SAMPLE_WIDTH > DUTY_WIDTH) begin : g_drop_lsbs
            logic unused_sample_lsbs;
            assign unused_sample_lsbs = ^sample[SAMPLE_WIDTH-DUTY_WIDTH-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and period events
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic wrap;
    logic push;
    logic pop;

    assign fifo_empty   = (fifo_cnt_q == '0);
    assign sample_ready = (fifo_cnt_q != CNT_FULL);
    assign wrap         = (count_q == DUTY_TOP);
    assign push         = sample_valid && sample_ready;
    // The pop looks at the registered occupancy only: a sample arriving on
    // the wrap edge into an empty FIFO is not bypassed to the duty register.
    assign pop          = wrap && !fifo_empty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d    = count_q + 1'b1;
        duty_d     = duty_q;
        underrun_d = underrun_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        // Comparator uses the pre-edge count, so the output lags by a cycle.
        pwm_d = (count_q < duty_q);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            duty_d   = mem_q[rd_ptr_q];
        end else if (wrap) begin
`ifdef PWM_DAC_SINK_MUTE_ON_UNDERRUN_EN
            duty_d = DUTY_MID;
`else
            duty_d = duty_q;
`endif
        end

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // A new underrun event takes priority over a clear in the same cycle.
        if (wrap && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            duty_q     <= DUTY_MID;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_duty;
        end
    end

    assign pwm_out    = pwm_q;
    assign underrun   = underrun_q;
    assign fifo_count = fifo_cnt_q;

endmodule

// File: tb/tb_pwm_dac_sink.sv
// tb/tb_pwm_dac_sink.sv - self-checking bench for pwm_dac_sink

module tb_pwm_dac_sink;

    localparam int PERIOD = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        underrun_clr = 1'b0;
    logic        pwm_out;
    logic        underrun;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    int tb_cyc;
    int acc;
    int obs_q[$];
    int exp_q[$];

    pwm_dac_sink dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun_clr (underrun_clr),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    // Bench-side cycle counter: value k means k rising edges since release.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= 0;
        else      tb_cyc <= tb_cyc + 1;
    end

    // Period k's output occupies the samples after edges 1024k+1 .. 1024k+1024.
    always @(negedge clk) begin
        if (!rst) begin
            acc = 0;
        end else if (tb_cyc > 0) begin
            acc += int'(pwm_out);
            if (tb_cyc % PERIOD == 0) begin
                obs_q.push_back(acc);
                acc = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int model_duty(input int s);
        return ((s >>> 4) + 512) & 1023;
    endfunction

    task automatic wait_cyc(input int n);
        int budget = 0;
        while (tb_cyc < n && budget < 20000) begin
            @(posedge clk);
            #1;
            budget++;
        end
    endtask

    task automatic wait_obs(input int n);
        int budget = 0;
        while (obs_q.size() < n && budget < 12000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL wait_obs periods seen %0d required %0d", obs_q.size(), n);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic push_sample(input logic [13:0] s);
        logic rdy;
        sample = s;
        sample_valid = 1'b1;
        rdy = sample_ready;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL push_ready got %b required 1", rdy);
        end
    endtask

    task automatic test_reset();
        int got, exp;
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pwm_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_pwm got %b required 0", pwm_out);
            end
        end
        checks++;
        if (fifo_count !== 3'd0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state count %0d underrun %b required 0 0", fifo_count, underrun);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", sample_ready);
        end
        exp_q.push_back(512);
        exp_q.push_back(512);
        wait_cyc(1023);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_underrun_pre got %b required 0", underrun);
        end
        wait_cyc(1024);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL reset_underrun_wrap got %b required 1", underrun);
        end
        wait_obs(2);
        for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_period%0d high %0d required %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_conversion();
        int got, exp;
        apply_reset();
        exp_q.push_back(512);
        push_sample(14'h2000); exp_q.push_back(0);
        push_sample(14'h0000); exp_q.push_back(512);
        push_sample(14'h1FFF); exp_q.push_back(1023);
        wait_obs(4);
        for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL conv_period%0d high %0d required %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got, exp;
        logic rdy;
        apply_reset();
        exp_q.push_back(512);
        while (tb_cyc < 10 * PERIOD) begin
            sample = 14'(idx * 64);
            sample_valid = 1'b1;
            rdy = sample_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                exp_q.push_back(model_duty(idx * 64));
                checks++;
                if ((idx < 4 && tb_cyc != idx + 1) || (idx >= 4 && tb_cyc % PERIOD != 1)) begin
                    errors++;
                    $display("FAIL bp_accept%0d at cycle %0d", idx, tb_cyc);
                end
                idx++;
            end
            if (tb_cyc == 4) begin
                checks++;
                if (sample_ready !== 1'b0 || fifo_count !== 3'd4) begin
                    errors++;
                    $display("FAIL bp_full ready %b count %0d required 0 4", sample_ready, fifo_count);
                end
            end
        end
        sample_valid = 1'b0;
        checks++;
        if (idx != 13) begin
            errors++;
            $display("FAIL bp_total accepts %0d required 13", idx);
        end
        wait_obs(10);
        for (int i = 0; i < 10 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bp_period%0d high %0d required %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_underrun();
        int got, exp, held;
`ifdef PWM_DAC_SINK_MUTE_ON_UNDERRUN_EN
        held = 512;
`else
        held = 768;
`endif
        apply_reset();
        exp_q.push_back(512);
        push_sample(14'h1000);
        exp_q.push_back(768);
        exp_q.push_back(held);
        exp_q.push_back(held);
        wait_cyc(2047);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL ur_pre got %b required 0", underrun);
        end
        wait_cyc(2048);
        checks++;
        if (underrun !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ur_set underrun %b count %0d required 1 0", underrun, fifo_count);
        end
        wait_cyc(2100);
        underrun_clr = 1'b1;
        wait_cyc(2101);
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL ur_clear got %b required 0", underrun);
        end
        wait_cyc(3071);
        underrun_clr = 1'b1;
        wait_cyc(3072);
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL ur_set_wins got %b required 1", underrun);
        end
        wait_obs(4);
        for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ur_period%0d high %0d required %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int got, exp;
        apply_reset();
        exp_q.push_back(512);
        push_sample(14'h3000); exp_q.push_back(model_duty(-4096));
        push_sample(14'h0800); exp_q.push_back(model_duty(2048));
        push_sample(14'h1FFF); exp_q.push_back(model_duty(8191));
        wait_cyc(2047);
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL b2b_pre count %0d required 2", fifo_count);
        end
        push_sample(14'h2010); exp_q.push_back(model_duty(-8176));
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL b2b_same_edge count %0d required 2", fifo_count);
        end
`ifdef PWM_DAC_SINK_MUTE_ON_UNDERRUN_EN
        exp_q.push_back(512);
`else
        exp_q.push_back(model_duty(-8176));
`endif
        wait_cyc(5119);
        checks++;
        if (fifo_count !== 3'd0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty count %0d underrun %b required 0 0", fifo_count, underrun);
        end
        push_sample(14'h3FFF); exp_q.push_back(model_duty(-1));
        checks++;
        if (fifo_count !== 3'd1 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bypass count %0d underrun %b required 1 1", fifo_count, underrun);
        end
        wait_obs(7);
        for (int i = 0; i < 7 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_period%0d high %0d required %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        int got, exp;
        apply_reset();
        wait_cyc(1024);
        push_sample(14'h1000);
        push_sample(14'h1000);
        push_sample(14'h1000);
        wait_cyc(1324);
        checks++;
        if (fifo_count !== 3'd3 || pwm_out !== 1'b1 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre count %0d pwm %b underrun %b required 3 1 1", fifo_count, pwm_out, underrun);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 1'b0 || fifo_count !== 3'd0 || underrun !== 1'b0 || sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_immediate pwm %b count %0d underrun %b ready %b required 0 0 0 1",
                     pwm_out, fifo_count, underrun, sample_ready);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(512);
        exp_q.push_back(512);
        wait_cyc(1023);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL ar_underrun_pre got %b required 0", underrun);
        end
        wait_cyc(1024);
        checks++;
        if (underrun !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ar_discarded underrun %b count %0d required 1 0", underrun, fifo_count);
        end
        wait_obs(2);
        for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ar_period%0d high %0d required %0d", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_backpressure();
        test_underrun();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
